// File: rtl/elastic_pipe_reg.sv
// Elastic inter-stage pipeline register: DEPTH-entry circular buffer with valid/ready
// handshake, synchronous flush, bubble payload when empty and a saturating stall counter.
module elastic_pipe_reg #(
  parameter int               WIDTH  = 256,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int             CW       = $clog2(DEPTH + 1);
  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_stall;
  logic             w_push;
  logic             w_pop;

  // Handshake flags come only from the occupancy register, never from the other side.
  assign in_ready  = (r_count < DEPTH_C);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign out_data  = out_valid ? r_mem[r_head] : BUBBLE;
  assign count     = r_count;
  assign stall_cnt = r_stall;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= f_next(r_tail);
      if (w_pop)  r_head <= f_next(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && w_push) r_mem[r_tail] <= in_data;
  end

  // Stall accounting survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if (out_valid && !out_ready && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Scoreboard bench for elastic_pipe_reg: a DEPTH=2/CNT_W=4 instance for directed cases and a
// DEPTH=3 instance with non-zero bubble for randomised wrap-around traffic.
module tb_elastic_pipe_reg;

  localparam int          W    = 16;
  localparam logic [15:0] BUB1 = 16'hDEAD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, flush_a, iv_a, ir_a, ov_a, or_a;
  logic [W-1:0]  id_a, od_a;
  logic [1:0]    cnt_a;
  logic [3:0]    st_a;

  logic          rst_b, flush_b, iv_b, ir_b, ov_b, or_b;
  logic [W-1:0]  id_b, od_b;
  logic [1:0]    cnt_b;
  logic [7:0]    st_b;

  elastic_pipe_reg #(.WIDTH(W), .DEPTH(2), .BUBBLE(16'h0000), .CNT_W(4)) u_d2 (
    .clk(clk), .rst(rst_a), .flush(flush_a), .in_valid(iv_a), .in_ready(ir_a),
    .in_data(id_a), .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
    .count(cnt_a), .stall_cnt(st_a)
  );

  elastic_pipe_reg #(.WIDTH(W), .DEPTH(3), .BUBBLE(BUB1), .CNT_W(8)) u_d3 (
    .clk(clk), .rst(rst_b), .flush(flush_b), .in_valid(iv_b), .in_ready(ir_b),
    .in_data(id_b), .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
    .count(cnt_b), .stall_cnt(st_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];
  int           m_st_a = 0;
  int           m_st_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input int k, input string tag);
    if (k == 0) begin
      chk({tag, ":count"},     32'(cnt_a), 32'(q_a.size()));
      chk({tag, ":out_valid"}, 32'(ov_a),  32'(q_a.size() != 0));
      chk({tag, ":in_ready"},  32'(ir_a),  32'(q_a.size() < 2));
      chk({tag, ":out_data"},  32'(od_a),  (q_a.size() != 0) ? 32'(q_a[0]) : 32'h0);
      chk({tag, ":stall_cnt"}, 32'(st_a),  32'(m_st_a));
    end else begin
      chk({tag, ":count"},     32'(cnt_b), 32'(q_b.size()));
      chk({tag, ":out_valid"}, 32'(ov_b),  32'(q_b.size() != 0));
      chk({tag, ":in_ready"},  32'(ir_b),  32'(q_b.size() < 3));
      chk({tag, ":out_data"},  32'(od_b),  (q_b.size() != 0) ? 32'(q_b[0]) : 32'(BUB1));
      chk({tag, ":stall_cnt"}, 32'(st_b),  32'(m_st_b));
    end
  endtask

  // Check outputs of the previous edge, drive one cycle of stimulus, advance the model.
  task automatic step(input int k, input bit do_chk, input bit r, input bit fl,
                      input bit iv, input logic [W-1:0] d, input bit ordy, input string tag);
    bit m_ir, m_ov;
    if (do_chk) check_outputs(k, tag);
    if (k == 0) begin
      rst_a = r; flush_a = fl; iv_a = iv; id_a = d; or_a = ordy;
      m_ir = (q_a.size() < 2); m_ov = (q_a.size() != 0);
      if (r) begin
        q_a.delete(); m_st_a = 0;
      end else begin
        if (m_ov && !ordy && m_st_a < 15) m_st_a++;
        if (fl) q_a.delete();
        else begin
          if (m_ov && ordy) void'(q_a.pop_front());
          if (iv && m_ir) q_a.push_back(d);
        end
      end
    end else begin
      rst_b = r; flush_b = fl; iv_b = iv; id_b = d; or_b = ordy;
      m_ir = (q_b.size() < 3); m_ov = (q_b.size() != 0);
      if (r) begin
        q_b.delete(); m_st_b = 0;
      end else begin
        if (m_ov && !ordy && m_st_b < 255) m_st_b++;
        if (fl) q_b.delete();
        else begin
          if (m_ov && ordy) void'(q_b.pop_front());
          if (iv && m_ir) q_b.push_back(d);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1; flush_a = 1'b0; iv_a = 1'b0; id_a = '0; or_a = 1'b0;
    rst_b = 1'b1; flush_b = 1'b0; iv_b = 1'b0; id_b = '0; or_b = 1'b0;
    @(negedge clk);

    // Reset with in_valid asserted must leave the buffer empty.
    step(0, 0, 1, 0, 1, 16'h1111, 1, "rst");
    step(0, 0, 1, 0, 1, 16'h2222, 1, "rst");
    check_outputs(0, "reset");

    // Streaming at full rate: occupancy stays 1, no bubbles.
    step(0, 1, 0, 0, 1, 16'h000A, 1, "strm0");
    step(0, 1, 0, 0, 1, 16'h000B, 1, "strm1");
    step(0, 1, 0, 0, 1, 16'h000C, 1, "strm2");
    step(0, 1, 0, 0, 0, 16'h0000, 1, "strm3");
    step(0, 1, 0, 0, 0, 16'h0000, 1, "strm4");

    // Backpressure: third beat refused, head holds, stall counts, then drain in order.
    step(0, 1, 0, 0, 1, 16'h000A, 0, "bp0");
    step(0, 1, 0, 0, 1, 16'h000B, 0, "bp1");
    step(0, 1, 0, 0, 1, 16'h000C, 0, "bp2");
    chk("bp_full_count", 32'(cnt_a), 32'd2);
    chk("bp_head_hold",  32'(od_a),  32'h000A);
    step(0, 1, 0, 0, 0, 16'h0000, 0, "bp3");
    step(0, 1, 0, 0, 0, 16'h0000, 1, "bp4");
    step(0, 1, 0, 0, 0, 16'h0000, 1, "bp5");
    step(0, 1, 0, 0, 0, 16'h0000, 1, "bp6");

    // Flush while full with a push in the same cycle: nothing survives.
    step(0, 1, 0, 0, 1, 16'h0031, 0, "fl0");
    step(0, 1, 0, 0, 1, 16'h0032, 0, "fl1");
    step(0, 1, 0, 1, 1, 16'h0077, 0, "fl2");
    chk("flush_in_ready", 32'(ir_a), 32'd1);
    step(0, 1, 0, 0, 1, 16'h0041, 1, "fl3");
    step(0, 1, 0, 1, 1, 16'h0042, 1, "fl_pop");
    step(0, 1, 0, 0, 0, 16'h0000, 1, "fl4");

    // Saturation of the 4-bit stall counter.
    step(0, 0, 1, 0, 0, 16'h0000, 0, "rst2");
    step(0, 1, 0, 0, 1, 16'h00F0, 0, "sat_push");
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 16'h0000, 0, "sat");
    chk("sat_value", 32'(st_a), 32'd15);
    step(0, 1, 0, 0, 0, 16'h0000, 1, "sat_drain");
    step(0, 1, 0, 0, 0, 16'h0000, 1, "sat_end");

    // DEPTH=3 random traffic with occasional flush exercises pointer wrap.
    step(1, 0, 1, 0, 0, 16'h0000, 0, "rstb");
    check_outputs(1, "reset_b");
    for (int i = 0; i < 1000; i++) begin
      step(1, 1, 0, ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
           16'($urandom), ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1, "rnd");
      if (cnt_b > 2'd3) chk("rnd_overflow", 32'(cnt_b), 32'd3);
    end
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 16'h0000, 1, "rnd_drain");
    check_outputs(1, "final_b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
